// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t   : FSM encoding (IDLE, SHIFT)
//   DEF_WIDTH : default operand/result width
//   cnt_w()   : bit-counter width for a given operand width
package serial_sub_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int DEF_WIDTH = 8;

  // The counter only needs to reach WIDTH-1; WIDTH is at least 2, so this is >= 1.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
//   start, a, b              : request (master -> slave)
//   busy, done, diff, borrow : status/result (slave -> master)
//   ovf                      : signed overflow, only with SERIAL_SUBTRACTOR_OVF_EN
interface serial_subtractor_if #(parameter int WIDTH = serial_sub_pkg::DEF_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;

  modport master (output start, a, b, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo = borrow out.
// Built as two half-subtractor stages: (x - y), then (that - bi).
//   x, y, bi : minuend bit, subtrahend bit, borrow in
//   d, bo    : difference bit, borrow out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  logic d1, b1, b2;

  assign d1 = x ^ y;
  assign b1 = ~x & y;
  assign d  = d1 ^ bi;
  assign b2 = ~d1 & bi;
  assign bo = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Operands are captured on an accepted start (IDLE only); the result lands
// in diff/borrow with a one-cycle done strobe WIDTH edges later.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : start/a/b in; busy/done/diff/borrow out
// Optional: SERIAL_SUBTRACTOR_OVF_EN adds bus.ovf (signed overflow).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CW-1:0]    cnt;
  logic             bi;
  logic             d, bo;
  logic             accept, last;

  full_subtractor u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (bi),
    .d  (d),
    .bo (bo)
  );

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept   = 1'b1;
        state_nx = SHIFT;
      end
      SHIFT: if (cnt == CW'(WIDTH-1)) begin
        last     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign bus.busy = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      cnt        <= '0;
      bi         <= 1'b0;
      bus.done   <= 1'b0;
      bus.diff   <= '0;
      bus.borrow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        a_sr <= bus.a;
        b_sr <= bus.b;
        cnt  <= '0;
        bi   <= 1'b0;
      end else if (state == SHIFT) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        r_sr <= {d, r_sr[WIDTH-1:1]};
        bi   <= bo;
        cnt  <= cnt + CW'(1);
        // Final bit goes straight to the output, not via r_sr.
        if (last) begin
          bus.diff   <= {d, r_sr[WIDTH-1:1]};
          bus.borrow <= bo;
          bus.done   <= 1'b1;
        end
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand sign bits are gone from the shift registers by completion.
  logic a_msb, b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      bus.ovf <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= bus.a[WIDTH-1];
        b_msb <= bus.b[WIDTH-1];
      end
      // d on the last cycle is the result MSB.
      if (last) bus.ovf <= (a_msb != b_msb) && (d != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  typedef struct {
    logic [7:0] a, b, diff;
    logic       borrow, ovf;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       borrow, ovf;
  } exp_t;

  exp_t       sb8[$];
  exp_t       sb4[$];
  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] last_diff = 8'h00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic bo, input logic ov);
    exp_t e;
    e.diff = d; e.borrow = bo; e.ovf = ov;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b;
    sb8.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  // Waits for done (negedge sampling), then pops and compares the scoreboard.
  task automatic wait_done8(input int c0, output int cyc, output int busy_n);
    exp_t e;
    cyc = c0; busy_n = 0;
    while (!bus8.done && cyc < 40) begin
      if (bus8.busy) busy_n++;
      if (cyc == 4) chk("diff_hold_in_shift", bus8.diff, last_diff);
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", bus8.done, 1'b1);
    if (bus8.done && sb8.size() > 0) begin
      e = sb8.pop_front();
      chk("diff", bus8.diff, e.diff);
      chk("borrow", bus8.borrow, e.borrow);
      chk("busy_low_at_done", bus8.busy, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk("ovf", bus8.ovf, e.ovf);
`endif
      last_diff = bus8.diff;
    end
  endtask

  initial begin
    vec_t vt[8];
    int cyc, bn, seen;
    exp_t e;
    logic [4:0] r4;

    vt[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vt[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vt[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[3] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vt[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vt[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vt[6] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
    vt[7] = '{8'h55, 8'h2A, 8'h2B, 1'b0, 1'b0};

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", bus8.busy, 1'b0);
    chk("rst_done", bus8.done, 1'b0);
    chk("rst_diff", bus8.diff, 8'h00);
    chk("rst_borrow", bus8.borrow, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, with latency/busy-length checks on every op
    for (int i = 0; i < 8; i++) begin
      start8(vt[i].a, vt[i].b, mk(vt[i].diff, vt[i].borrow, vt[i].ovf));
      wait_done8(0, cyc, bn);
      chk("latency", cyc, 8);
      chk("busy_cycles", bn, 8);
    end

    // start re-pulsed mid-operation: ignored, not queued
    start8(8'h05, 8'h03, mk(8'h02, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h11;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(3, cyc, bn);
    chk("repulse_latency", cyc, 8);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) seen++;
    end
    chk("no_queued_start", seen, 0);

    // start held across done: second op accepted in the done cycle
    bus8.start = 1'b1; bus8.a = 8'h03; bus8.b = 8'h05;
    sb8.push_back(mk(8'hFE, 1'b1, 1'b0));
    @(posedge clk);
    @(negedge clk);
    bus8.a = 8'h00; bus8.b = 8'hFF;
    sb8.push_back(mk(8'h01, 1'b1, 1'b0));
    wait_done8(0, cyc, bn);
    chk("held_first_latency", cyc, 8);
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(1, cyc, bn);
    chk("held_second_gap", cyc, 9);

    // Reset mid-operation
    @(negedge clk);
    start8(8'h55, 8'h2A, mk(8'h2B, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus8.busy, 1'b0);
    chk("abort_done", bus8.done, 1'b0);
    chk("abort_diff", bus8.diff, 8'h00);
    chk("abort_borrow", bus8.borrow, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("abort_ovf", bus8.ovf, 1'b0);
`endif
    sb8.delete();
    last_diff = 8'h00;
    seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) seen++;
    end
    chk("abort_no_done", seen, 0);
    start8(8'h10, 8'h01, mk(8'h0F, 1'b0, 1'b0));
    wait_done8(0, cyc, bn);
    chk("post_abort_latency", cyc, 8);

    // Exhaustive WIDTH=4 sweep against {borrow,diff} = {0,a} - {0,b}
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 4'(a); bus4.b = 4'(b);
        r4 = {1'b0, 4'(a)} - {1'b0, 4'(b)};
        e = mk({4'h0, r4[3:0]}, r4[4], (a[3] != b[3]) && (r4[3] != a[3]));
        sb4.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        cyc = 0;
        while (!bus4.done && cyc < 20) begin
          @(negedge clk);
          cyc++;
        end
        chk("w4_done_seen", bus4.done, 1'b1);
        if (bus4.done && sb4.size() > 0) begin
          e = sb4.pop_front();
          if (bus4.diff !== e.diff[3:0] || bus4.borrow !== e.borrow) begin
            $display("FAIL w4 %0h-%0h: got diff %0h borrow %0b, expected diff %0h borrow %0b",
                     a, b, bus4.diff, bus4.borrow, e.diff[3:0], e.borrow);
            nerr++;
          end
          nvec++;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          chk("w4_ovf", bus4.ovf, e.ovf);
`endif
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
